// File: rtl/dice_scorer.sv
// dice_scorer: captures each settled dice throw after button release, validates it,
// accumulates a saturating per-game total and drives the 7-LED pip display.
module dice_scorer #(
  parameter int ROLLS_PER_GAME = 5,
  parameter int TOTAL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               button,
  input  logic [2:0]         throw,
  output logic [2:0]         result,
  output logic               result_valid,
  output logic [6:0]         pips,
  output logic [TOTAL_W-1:0] total,
  output logic [3:0]         roll_count,
  output logic               game_over,
  output logic               bad_throw
);
  typedef enum logic [1:0] {IDLE, ROLLING, CAPTURE} state_t;
  state_t state;
  logic [TOTAL_W:0] sum;
  logic legal;
  logic [3:0] next_count;
  function automatic logic [6:0] decode(input logic [2:0] v);
    case (v)
      3'd1: return 7'h08;
      3'd2: return 7'h41;
      3'd3: return 7'h49;
      3'd4: return 7'h63;
      3'd5: return 7'h6B;
      3'd6: return 7'h77;
      default: return 7'h00;
    endcase
  endfunction
  // one extra bit catches the carry so the total saturates instead of wrapping
  assign sum = {1'b0, total} + (TOTAL_W+1)'(throw);
  assign legal = throw != 3'd0 && throw != 3'd7;
  assign next_count = roll_count + 4'd1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      result <= '0;
      result_valid <= 1'b0;
      pips <= '0;
      total <= '0;
      roll_count <= '0;
      game_over <= 1'b0;
      bad_throw <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      pips <= decode(state == ROLLING ? throw : result);
      case (state)
        IDLE: if (button) begin
          state <= ROLLING;
          bad_throw <= 1'b0;
          if (game_over) begin
            total <= '0;
            roll_count <= '0;
            game_over <= 1'b0;
          end
        end
        ROLLING: if (!button) state <= CAPTURE;
        CAPTURE: begin
          state <= IDLE;
          if (legal) begin
            result <= throw;
            result_valid <= 1'b1;
            total <= sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
            roll_count <= next_count;
            game_over <= next_count == 4'(ROLLS_PER_GAME);
          end else begin
            bad_throw <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dice_scorer.md
# dice_scorer

Consumer end of the electronic dice's `throw` interface. It watches the same `button` that drives the dice and detects the release. Once the dice has stopped, it captures the settled `throw`, validates it, and accumulates a per-game total over a fixed number of rolls. It also drives a 7-LED pip pattern for the board display, showing the live value while rolling and the held result otherwise.

## Interface
Parameters:
- `ROLLS_PER_GAME`, default 5: rolls per game; legal range 1..15.
- `TOTAL_W`, default 8: width of the running total.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset is asynchronous and active-high.
- `button` in 1: same synchronous button level fed to the dice; high = rolling.
- `throw` in 3: dice value; legal 1..6; holds while `button` is low.
- `result` out 3: last accepted throw.
- `result_valid` out 1: one-cycle pulse when `result` and `total` update.
- `pips` out 7: LED pattern, bit order {TL,TR,ML,C,MR,BL,BR} = [6:0].
- `total` out TOTAL_W: saturating sum of accepted throws in the current game.
- `roll_count` out 4: accepted rolls in the current game.
- `game_over` out 1: high once `roll_count` == ROLLS_PER_GAME.
- `bad_throw` out 1: sticky; set when the captured throw was 0 or 7.

## Operation
- All outputs are registered. Reset value of every output and every state bit is 0; the state resets to IDLE.
- FSM states and transitions:
  - IDLE: if `button`==1, go to ROLLING. On that same edge, clear `bad_throw`. If `game_over`==1, also clear `total`, `roll_count` and `game_over` (new game).
  - ROLLING: stay while `button`==1. On the first edge with `button`==0, go to CAPTURE.
  - CAPTURE: lasts exactly one cycle, then always goes to IDLE. It samples `throw`, which has been stable since the release edge.
    - If the throw is 1..6: `result`<=`throw`; `result_valid`<=1; `total`<=min(`total`+`throw`, 2^TOTAL_W-1); `roll_count`+=1. If the new `roll_count`==ROLLS_PER_GAME, set `game_over`<=1.
    - If the throw is 0 or 7: set `bad_throw`<=1. `result`, `total`, `roll_count` and `result_valid` are unchanged (no pulse).
- Addition is done in TOTAL_W+1 bits, then saturated; it never wraps.
- `roll_count` cannot exceed ROLLS_PER_GAME: no capture can occur after `game_over` without first passing the IDLE clear.
- `pips` is registered every cycle:
  - In ROLLING it shows decode(`throw`).
  - Otherwise it shows decode(`result`).
  - Decode table: 1→0x08, 2→0x41, 3→0x49, 4→0x63, 5→0x6B, 6→0x77, 0/7→0x00.
- `button` pulses of any length, including 1 cycle, produce one full roll: IDLE→ROLLING→CAPTURE.
- If `button` rises again during CAPTURE, it is honoured one cycle later from IDLE.
- Asserting `rst` at any time, including mid-ROLLING or in CAPTURE, immediately zeroes all outputs. No capture or pulse occurs for the interrupted roll.

## Timing
- Edge k: first rising edge sampling `button`==0 while in ROLLING. The state becomes CAPTURE.
- Edge k+1: `result`, `total`, `roll_count`, `game_over` and `bad_throw` update. `result_valid` is high from k+1 to k+2 only. `pips` reflects the new `result` from edge k+2.
- Release-to-`result_valid` latency is 2 edges.
- Press-to-ROLLING is 1 edge. Live `pips` lag `throw` by 1 cycle.
- Minimum roll cycle is 3 clocks (IDLE, ROLLING, CAPTURE).
- `result_valid` never asserts in two consecutive cycles.

## Test plan
- Reset, then hold `button` for 4 cycles with the dice model stopping at 4, then release.
  - Required: `result_valid` pulses exactly once, 2 edges after release.
  - Required: `result`=4, `total`=4, `roll_count`=1, `pips`=0x63.
- ROLLS_PER_GAME=3, throws 6,5,2.
  - Required: `total`=13 and `game_over`=1 after the third pulse.
  - Then press again. Required: on the press edge `total`=0, `roll_count`=0, `game_over`=0; the next throw of 3 gives `total`=3.
- Force `throw`=7 at release.
  - Required: `bad_throw`=1, no `result_valid`, `result`/`total`/`roll_count` unchanged, `pips` unchanged.
  - On the next press: `bad_throw` returns to 0.
- TOTAL_W=4, ROLLS_PER_GAME=5, throws 6,6,6.
  - Required: `total` reads 6, 12, 15 (saturated, not 2).
- Assert `rst` for 1 cycle while in ROLLING, with `button` held.
  - Required: all outputs 0 immediately.
  - After `rst` drops with `button` still high: ROLLING re-entered; the subsequent release yields a normal capture with `roll_count`=1.
- 1-cycle `button` pulse, then a second press arriving during CAPTURE.
  - Required: first capture pulses.
  - Required: ROLLING entered one cycle after the CAPTURE-to-IDLE edge; second roll captured normally.
